// File: rtl/ahb_rcu_core_if.sv
// AHB slave-side bus bundle for ahb_rcu_core: transfer qualifiers, write data
// and the two slave responses.
interface ahb_rcu_core_if;
  logic [1:0]   HTRANS;
  logic         HWRITE;
  logic         HSELx;
  logic         HREADY;
  logic [127:0] HWDATA;
  logic         HRESP;
  logic         HREADYOUT;

  modport master (
    output HTRANS, HWRITE, HSELx, HREADY, HWDATA,
    input  HRESP, HREADYOUT
  );

  modport slave (
    input  HTRANS, HWRITE, HSELx, HREADY, HWDATA,
    output HRESP, HREADYOUT
  );
endinterface

// File: rtl/ahb_rcu_core.sv
// ahb_rcu_core: AHB-fed block transform engine. A 128-bit key is loaded and
// expanded into an 11-entry XOR/rotate schedule (only k0 and k10 are kept),
// the host is interrupted, then an SRAM address and a stream of 128-bit
// blocks are accepted. Each block is transformed in 11 cycles, stepping the
// key schedule forward (encrypt) or backward (decrypt) on the fly.
module ahb_rcu_core (
  input  logic                clk,
  input  logic                n_rst,
  ahb_rcu_core_if.slave       ahb,
  input  logic                enable,
  input  logic                irq_resp,
  input  logic                e_or_d,
  input  logic                data_done,
  output logic [31:0]         sram_addr,
  output logic                read_addr,
  output logic                last_packet,
  output logic                aes_done,
  output logic [128:0]        data_out,
  output logic                irq,
  output logic                ready
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KEY    = 3'd1,
    S_EXPAND = 3'd2,
    S_IRQ    = 3'd3,
    S_SVC    = 3'd4,
    S_ADDR   = 3'd5,
    S_DATA   = 3'd6,
    S_PROC   = 3'd7
  } state_t;

  state_t        state_q;
  logic [127:0]  k0_q;
  logic [127:0]  k10_q;
  logic [127:0]  kw_q;        // working key, k[r] of the current round
  logic [127:0]  s_q;         // block state
  logic [3:0]    rnd_q;
  logic          mode_q;      // 1 = encrypt
  logic          last_q;
  logic [31:0]   sram_addr_q;
  logic [128:0]  data_out_q;
  logic          aes_done_q;

  logic          wsel;
  logic [127:0]  kfwd_d;
  logic [127:0]  kbwd_d;
  logic [127:0]  kstep_d;
  logic [127:0]  s_d;

  function automatic logic [127:0] rotl32(input logic [127:0] x);
    return {x[95:0], x[127:96]};
  endfunction

  function automatic logic [127:0] rotr32(input logic [127:0] x);
    return {x[31:0], x[127:32]};
  endfunction

  function automatic logic [127:0] rotl8(input logic [127:0] x);
    return {x[119:0], x[127:120]};
  endfunction

  function automatic logic [127:0] rotr8(input logic [127:0] x);
    return {x[7:0], x[127:8]};
  endfunction

  assign wsel = ahb.HSELx & ahb.HREADY & ahb.HWRITE & ahb.HTRANS[1];

  // Round datapath: forward/backward key step and the next block state.
  // Decrypt round j undoes schedule index 11-j, so the backward step XORs
  // that index before rotating.
  always_comb begin
    kfwd_d  = rotl32(kw_q) ^ {124'd0, rnd_q};
    kbwd_d  = rotr32(kw_q ^ {124'd0, 4'd11 - rnd_q});
    kstep_d = kw_q;
    s_d     = s_q ^ kw_q;
    if (rnd_q == 4'd0) begin
      kstep_d = kw_q;
      s_d     = s_q ^ kw_q;
    end else if (mode_q) begin
      kstep_d = kfwd_d;
      s_d     = rotl8(s_q) ^ kfwd_d;
    end else begin
      kstep_d = kbwd_d;
      s_d     = rotr8(s_q) ^ kbwd_d;
    end
  end

  // Control FSM with key, block and result registers; abort returns to IDLE
  // but keeps the last result and SRAM address.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= S_IDLE;
      k0_q        <= 128'd0;
      k10_q       <= 128'd0;
      kw_q        <= 128'd0;
      s_q         <= 128'd0;
      rnd_q       <= 4'd0;
      mode_q      <= 1'b0;
      last_q      <= 1'b0;
      sram_addr_q <= 32'd0;
      data_out_q  <= 129'd0;
      aes_done_q  <= 1'b0;
    end else begin
      aes_done_q <= 1'b0;
      if ((state_q != S_IDLE) && !enable) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (enable && wsel) begin
              mode_q  <= e_or_d;
              state_q <= S_KEY;
            end
          end
          S_KEY: begin
            k0_q    <= ahb.HWDATA;
            kw_q    <= ahb.HWDATA;
            rnd_q   <= 4'd1;
            state_q <= S_EXPAND;
          end
          S_EXPAND: begin
            kw_q <= kfwd_d;
            if (rnd_q == 4'd10) begin
              k10_q   <= kfwd_d;
              state_q <= S_IRQ;
            end else begin
              rnd_q <= rnd_q + 4'd1;
            end
          end
          S_IRQ: begin
            if (irq_resp) begin
              state_q <= S_SVC;
            end
          end
          S_SVC: begin
            if (wsel) begin
              state_q <= S_ADDR;
            end
          end
          S_ADDR: begin
            sram_addr_q <= ahb.HWDATA[31:0];
            state_q     <= S_DATA;
          end
          S_DATA: begin
            s_q     <= ahb.HWDATA;
            last_q  <= data_done;
            kw_q    <= mode_q ? k0_q : k10_q;
            rnd_q   <= 4'd0;
            state_q <= S_PROC;
          end
          S_PROC: begin
            s_q  <= s_d;
            kw_q <= kstep_d;
            if (rnd_q == 4'd10) begin
              data_out_q <= {last_q, s_d};
              aes_done_q <= 1'b1;
              state_q    <= last_q ? S_IDLE : S_DATA;
            end else begin
              rnd_q <= rnd_q + 4'd1;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign ready         = (state_q == S_IDLE);
  assign irq           = (state_q == S_IRQ);
  assign read_addr     = (state_q == S_ADDR);
  assign last_packet   = (state_q == S_PROC) & last_q;
  assign ahb.HREADYOUT = (state_q != S_PROC);
  assign ahb.HRESP     = 1'b0;
  assign sram_addr     = (state_q == S_ADDR) ? ahb.HWDATA[31:0] : sram_addr_q;
  assign aes_done      = aes_done_q;
  assign data_out      = data_out_q;

endmodule

// File: tb/tb_ahb_rcu_core.sv
// Self-checking bench for ahb_rcu_core: randomized keys/blocks against a
// behavioural model of the key schedule and block transform.
module tb_ahb_rcu_core;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          enable;
  logic          irq_resp;
  logic          e_or_d;
  logic          data_done;
  logic [31:0]   sram_addr;
  logic          read_addr;
  logic          last_packet;
  logic          aes_done;
  logic [128:0]  data_out;
  logic          irq;
  logic          ready;

  ahb_rcu_core_if bus_if ();

  ahb_rcu_core dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .ahb         (bus_if.slave),
    .enable      (enable),
    .irq_resp    (irq_resp),
    .e_or_d      (e_or_d),
    .data_done   (data_done),
    .sram_addr   (sram_addr),
    .read_addr   (read_addr),
    .last_packet (last_packet),
    .aes_done    (aes_done),
    .data_out    (data_out),
    .irq         (irq),
    .ready       (ready)
  );

  always #5 clk = ~clk;

  int n_cmp     = 0;
  int n_err     = 0;
  int pulse_cnt = 0;

  logic [127:0] ks   [0:10];
  logic [127:0] din  [0:15];
  logic [127:0] dexp [0:15];
  logic [127:0] pt   [0:15];
  logic [127:0] ct   [0:15];

  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (aes_done === 1'b1) pulse_cnt++;
  endtask

  function automatic logic [127:0] rotl(input logic [127:0] x, input int n);
    return (x << n) | (x >> (128 - n));
  endfunction

  function automatic logic [127:0] rotr(input logic [127:0] x, input int n);
    return (x >> n) | (x << (128 - n));
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic build_ks(input logic [127:0] key);
    ks[0] = key;
    for (int r = 1; r <= 10; r++) ks[r] = rotl(ks[r-1], 32) ^ 128'(r);
  endtask

  function automatic logic [127:0] model_enc(input logic [127:0] p);
    logic [127:0] s;
    s = p ^ ks[0];
    for (int r = 1; r <= 10; r++) s = rotl(s, 8) ^ ks[r];
    return s;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] c);
    logic [127:0] s;
    s = c;
    for (int r = 10; r >= 1; r--) s = rotr(s ^ ks[r], 8);
    return s ^ ks[0];
  endfunction

  task automatic set_ws(input logic on);
    bus_if.HSELx  = on;
    bus_if.HREADY = 1'b1;
    bus_if.HWRITE = on;
    bus_if.HTRANS = on ? 2'b10 : 2'b00;
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_ready"}, ready, 1'b1);
    chk({pfx, "_irq"}, irq, 1'b0);
    chk({pfx, "_read_addr"}, read_addr, 1'b0);
    chk({pfx, "_aes_done"}, aes_done, 1'b0);
    chk({pfx, "_last_packet"}, last_packet, 1'b0);
    chk({pfx, "_hreadyout"}, bus_if.HREADYOUT, 1'b1);
    chk({pfx, "_hresp"}, bus_if.HRESP, 1'b0);
    chk({pfx, "_sram_addr"}, sram_addr, 32'd0);
    chk({pfx, "_data_out"}, data_out, 129'd0);
  endtask

  // Issue the start write in IDLE, then present the key in the KEY cycle.
  task automatic start_key(input logic mode, input logic [127:0] key);
    enable = 1'b1;
    e_or_d = mode;
    set_ws(1'b1);
    tick();
    set_ws(1'b0);
    bus_if.HWDATA = key;
    chk("ready_low_in_key", ready, 1'b0);
    tick();
  endtask

  // Full session: key, expand, irq handshake, address, n blocks.
  // rst_blk >= 0 applies n_rst=0 mid-PROC of that block and returns.
  task automatic run_session(input logic mode, input logic [127:0] key,
                             input logic [127:0] addr, input int n, input int rst_blk);
    int irq_hi;
    int lowcnt;
    int lpcnt;
    int hold;
    logic [128:0] last_out;
    start_key(mode, key);
    build_ks(key);
    irq_hi = 0;
    for (int i = 0; i < 10; i++) begin
      if (irq === 1'b1) irq_hi++;
      tick();
    end
    chk("irq_low_during_expand", irq_hi, 0);
    chk("irq_after_expand", irq, 1'b1);
    hold = $urandom_range(3, 1);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("irq_held", irq, 1'b1);
    end
    irq_resp = 1'b1;
    tick();
    irq_resp = 1'b0;
    chk("irq_cleared", irq, 1'b0);
    set_ws(1'b1);
    tick();
    set_ws(1'b0);
    bus_if.HWDATA = addr;
    #1;
    chk("read_addr_in_addr", read_addr, 1'b1);
    chk("sram_addr_comb", sram_addr, addr[31:0]);
    tick();
    chk("read_addr_after", read_addr, 1'b0);
    chk("sram_addr_held", sram_addr, addr[31:0]);
    pulse_cnt = 0;
    for (int b = 0; b < n; b++) begin
      bus_if.HWDATA = din[b];
      data_done = (b == n - 1);
      tick();
      data_done = 1'b0;
      bus_if.HWDATA = rnd128();
      lowcnt = 0;
      lpcnt  = 0;
      for (int c = 0; c < 11; c++) begin
        if (bus_if.HREADYOUT === 1'b0) lowcnt++;
        if (last_packet === 1'b1) lpcnt++;
        if (b == rst_blk && c == 5) begin
          n_rst = 1'b0;
          tick();
          n_rst  = 1'b1;
          enable = 1'b0;
          check_reset_vals("rst_in_proc");
          return;
        end
        tick();
      end
      chk("hreadyout_low_cycles", lowcnt, 11);
      chk("last_packet_cycles", lpcnt, (b == n - 1) ? 11 : 0);
      chk("aes_done_pulse", aes_done, 1'b1);
      chk("data_out", data_out, {(b == n - 1) ? 1'b1 : 1'b0, dexp[b]});
      chk("hreadyout_after_proc", bus_if.HREADYOUT, 1'b1);
    end
    chk("ready_after_last", ready, 1'b1);
    chk("aes_done_count", pulse_cnt, n);
    last_out = {1'b1, dexp[n-1]};
    tick();
    chk("aes_done_single", aes_done, 1'b0);
    chk("data_out_held", data_out, last_out);
  endtask

  initial begin
    logic [127:0] key;
    logic [128:0] saved;
    int irq_hi;
    n_rst = 1'b0; enable = 1'b0; irq_resp = 1'b0; e_or_d = 1'b0; data_done = 1'b0;
    set_ws(1'b0);
    bus_if.HWDATA = 128'd0;
    tick(); tick();
    n_rst = 1'b1;
    tick(); tick(); tick();
    check_reset_vals("reset");

    // Fixed key, 13 blocks: encrypt then decrypt the ciphertexts.
    key = 128'h5468617473206D79204B756E67204675;
    build_ks(key);
    pt[0] = 128'h00112233445566778899AABBCCDDEEFF;
    pt[1] = 128'd0;
    pt[2] = ~128'd0;
    for (int i = 3; i < 13; i++) pt[i] = rnd128();
    for (int i = 0; i < 13; i++) begin
      ct[i] = model_enc(pt[i]);
      chk("model_roundtrip", model_dec(ct[i]), pt[i]);
      din[i] = pt[i]; dexp[i] = ct[i];
    end
    run_session(1'b1, key, {96'hA5A5_0000_FFFF_1234_0000_0000, 32'h00001111}, 13, -1);
    for (int i = 0; i < 13; i++) begin din[i] = ct[i]; dexp[i] = pt[i]; end
    run_session(1'b0, key, rnd128(), 13, -1);

    // Random key, short streams in both directions.
    for (int t = 0; t < 2; t++) begin
      key = rnd128();
      build_ks(key);
      for (int i = 0; i < 4; i++) begin
        pt[i] = rnd128(); ct[i] = model_enc(pt[i]);
        din[i] = pt[i]; dexp[i] = ct[i];
      end
      run_session(1'b1, key, rnd128(), 4, -1);
      for (int i = 0; i < 4; i++) begin din[i] = ct[i]; dexp[i] = pt[i]; end
      run_session(1'b0, key, rnd128(), 4, -1);
    end

    // Abort during EXPAND.
    saved = data_out;
    start_key(1'b1, rnd128());
    tick(); tick();
    enable = 1'b0;
    tick();
    chk("abort_ready", ready, 1'b1);
    enable = 1'b1;
    irq_hi = 0;
    for (int i = 0; i < 15; i++) begin
      if (irq === 1'b1) irq_hi++;
      tick();
    end
    chk("abort_no_irq", irq_hi, 0);
    chk("abort_data_out_kept", data_out, saved);

    // Reset in the middle of PROC.
    key = rnd128();
    build_ks(key);
    for (int i = 0; i < 3; i++) begin pt[i] = rnd128(); din[i] = pt[i]; dexp[i] = model_enc(pt[i]); end
    run_session(1'b1, key, rnd128(), 3, 1);
    tick();
    check_reset_vals("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
